// File: rtl/oam_dma_if.sv
// OAM DMA bus bundle: CPU register port, source read port and OAM write port.
// The master modport is the DMA engine; the slave modport is the system-bus side.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic        cpu_enable;
  logic        cpu_write;
  logic [7:0]  cpu_data_out;
  logic        reg_select;
  logic [7:0]  reg_data_out;
  logic        dma_active;
  logic        cpu_blocked;
  logic [15:0] dma_addr;
  logic        dma_read_enable;
  logic [7:0]  dma_read_data;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_data;

  modport master (
    input  cpu_addr, cpu_enable, cpu_write, cpu_data_out, dma_read_data,
    output reg_select, reg_data_out, dma_active, cpu_blocked,
           dma_addr, dma_read_enable, oam_addr, oam_write, oam_data
  );

  modport slave (
    output cpu_addr, cpu_enable, cpu_write, cpu_data_out, dma_read_data,
    input  reg_select, reg_data_out, dma_active, cpu_blocked,
           dma_addr, dma_read_enable, oam_addr, oam_write, oam_data
  );
endinterface

// File: rtl/oam_dma.sv
// DMG OAM DMA engine owning register 0xFF46; copies LENGTH bytes from {src_hi,8'h00} into OAM.
// Optional macro OAM_DMA_BUS_CONFLICT_EN drives cpu_blocked high during XFER.
module oam_dma #(
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned LENGTH          = 160
) (
  input  logic      clk,
  input  logic      reset_n,
  oam_dma_if.master bus
);
  localparam int unsigned PW = (CYCLES_PER_BYTE > 2) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int unsigned IW = 9;
  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(LENGTH - 1);
  localparam logic [15:0]   REG_ADDR = 16'hFF46;

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      src_hi_q, src_hi_d;
  logic [7:0]      eff_hi_d;
  logic            trigger_c;
  logic            rd_en_d, wr_en_d;

  logic            dma_active_q;
  logic            rd_en_q;
  logic [15:0]     dma_addr_q;
  logic            wr_en_q;
  logic [7:0]      oam_addr_q;

  assign trigger_c = bus.cpu_enable && bus.cpu_write && (bus.cpu_addr == REG_ADDR);

  // Next-state: a trigger overrides everything, including the final phase of a byte.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    src_hi_d = src_hi_q;
    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        if (phase_q == PH_LAST) begin
          state_d = S_XFER;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_XFER: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) state_d = S_IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (trigger_c) begin
      src_hi_d = bus.cpu_data_out;
      state_d  = S_START;
      phase_d  = '0;
      idx_d    = '0;
    end
  end

  // 0xE0-0xFF pages alias WRAM (echo region).
  assign eff_hi_d = (src_hi_d >= 8'hE0) ? (src_hi_d - 8'h20) : src_hi_d;
  assign rd_en_d  = (state_d == S_XFER) && (phase_d == PW'(0));
  assign wr_en_d  = (state_d == S_XFER) && (phase_d == PW'(1));

  // State plus outputs registered from the next-state values so they align with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      idx_q        <= '0;
      src_hi_q     <= 8'hFF;
      dma_active_q <= 1'b0;
      rd_en_q      <= 1'b0;
      dma_addr_q   <= '0;
      wr_en_q      <= 1'b0;
      oam_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      src_hi_q     <= src_hi_d;
      dma_active_q <= (state_d != S_IDLE);
      rd_en_q      <= rd_en_d;
      dma_addr_q   <= rd_en_d ? {eff_hi_d, idx_d[7:0]} : 16'h0000;
      wr_en_q      <= wr_en_d;
      oam_addr_q   <= wr_en_d ? idx_d[7:0] : 8'h00;
    end
  end

`ifdef OAM_DMA_BUS_CONFLICT_EN
  logic blocked_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blocked_q <= 1'b0;
    else          blocked_q <= (state_d == S_XFER);
  end
  assign bus.cpu_blocked = blocked_q;
`else
  assign bus.cpu_blocked = 1'b0;
`endif

  assign bus.reg_select      = (bus.cpu_addr == REG_ADDR);
  assign bus.reg_data_out    = src_hi_q;
  assign bus.dma_active      = dma_active_q;
  assign bus.dma_read_enable = rd_en_q;
  assign bus.dma_addr        = dma_addr_q;
  assign bus.oam_write       = wr_en_q;
  assign bus.oam_addr        = oam_addr_q;
  // Source RAM data is valid during the write phase, so it passes straight through.
  assign bus.oam_data        = wr_en_q ? bus.dma_read_data : 8'h00;
endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: register-decode vector table plus multi-cycle transfer sequences.
`timescale 1ns/1ps
module tb_oam_dma;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  oam_dma_if bus ();
  oam_dma dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

`ifdef OAM_DMA_BUS_CONFLICT_EN
  localparam int EXP_BLK = 640;
`else
  localparam int EXP_BLK = 0;
`endif

  // Synchronous source RAM: byte at offset i holds i ^ 8'h5A.
  always @(posedge clk)
    if (bus.dma_read_enable) bus.dma_read_data <= bus.dma_addr[7:0] ^ 8'h5A;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [7:0] val);
    bus.cpu_addr     = 16'hFF46;
    bus.cpu_enable   = 1'b1;
    bus.cpu_write    = 1'b1;
    bus.cpu_data_out = val;
    tick();
    bus.cpu_enable   = 1'b0;
    bus.cpu_write    = 1'b0;
    bus.cpu_addr     = 16'h0000;
    check("trig_active", 32'(bus.dma_active), 32'd1);
  endtask

  typedef struct {
    int n_rd; int n_wr; int first_rd; int rd_err; int wr_err;
    int end_cyc; int blk; int blk_start; logic [15:0] last_rd;
  } stat_t;

  // Cycle 0 is the sample just after the trigger edge; stops at stop_cyc or when dma_active drops.
  task automatic observe(input logic [7:0] hi, input int stop_cyc, output stat_t s);
    s.n_rd = 0; s.n_wr = 0; s.first_rd = -1; s.rd_err = 0; s.wr_err = 0;
    s.end_cyc = -1; s.blk = 0; s.blk_start = 0; s.last_rd = 16'h0000;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == stop_cyc) return;
      if (!bus.dma_active) begin s.end_cyc = cyc; return; end
      if (bus.cpu_blocked) begin
        s.blk++;
        if (cyc < 4) s.blk_start++;
      end
      if (bus.dma_read_enable) begin
        if (s.first_rd < 0) s.first_rd = cyc;
        if (bus.dma_addr != {hi, 8'(s.n_rd)}) s.rd_err++;
        s.last_rd = bus.dma_addr;
        s.n_rd++;
      end
      if (bus.oam_write) begin
        if (bus.oam_addr != 8'(s.n_wr) || bus.oam_data != (8'(s.n_wr) ^ 8'h5A)) s.wr_err++;
        s.n_wr++;
      end
      tick();
    end
  endtask

  task automatic check_full(input string tag, input stat_t s, input logic [15:0] last);
    check({tag, "_first_rd"}, 32'(s.first_rd), 32'd4);
    check({tag, "_n_rd"},     32'(s.n_rd),     32'd160);
    check({tag, "_n_wr"},     32'(s.n_wr),     32'd160);
    check({tag, "_rd_err"},   32'(s.rd_err),   32'd0);
    check({tag, "_wr_err"},   32'(s.wr_err),   32'd0);
    check({tag, "_last_rd"},  32'(s.last_rd),  32'(last));
    check({tag, "_end"},      32'(s.end_cyc),  32'd644);
    check({tag, "_blk"},      32'(s.blk),      32'(EXP_BLK));
    check({tag, "_blk_start"},32'(s.blk_start),32'd0);
  endtask

  typedef struct {
    logic [15:0] addr; logic en; logic wr; logic [7:0] data;
    logic exp_sel; logic exp_active; logic [7:0] exp_reg;
  } vec_t;

  initial begin
    vec_t  vecs[6];
    stat_t s, s2;
    int    act;

    vecs[0] = '{16'hFF46, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, 8'hFF};
    vecs[1] = '{16'hFF46, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0, 8'hFF};
    vecs[2] = '{16'hFF47, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{16'hFF45, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 8'hFF};
    vecs[4] = '{16'h7F46, 1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, 8'hFF};
    vecs[5] = '{16'h0046, 1'b1, 1'b0, 8'hD0, 1'b0, 1'b0, 8'hFF};

    reset_n = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_enable = 1'b0; bus.cpu_write = 1'b0; bus.cpu_data_out = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_active",  32'(bus.dma_active),      32'd0);
    check("rst_rd",      32'(bus.dma_read_enable), 32'd0);
    check("rst_wr",      32'(bus.oam_write),       32'd0);
    check("rst_blk",     32'(bus.cpu_blocked),     32'd0);
    check("rst_dma_addr",32'(bus.dma_addr),        32'd0);
    check("rst_oam_addr",32'(bus.oam_addr),        32'd0);
    check("rst_oam_data",32'(bus.oam_data),        32'd0);
    check("rst_reg",     32'(bus.reg_data_out),    32'hFF);
    reset_n = 1'b1;
    tick();

    // Register decode: none of these may start a transfer.
    for (int i = 0; i < 6; i++) begin
      bus.cpu_addr = vecs[i].addr; bus.cpu_enable = vecs[i].en;
      bus.cpu_write = vecs[i].wr;  bus.cpu_data_out = vecs[i].data;
      #1;
      check($sformatf("vec%0d_sel", i), 32'(bus.reg_select), 32'(vecs[i].exp_sel));
      tick();
      bus.cpu_enable = 1'b0; bus.cpu_write = 1'b0;
      check($sformatf("vec%0d_active", i), 32'(bus.dma_active), 32'(vecs[i].exp_active));
      check($sformatf("vec%0d_reg", i), 32'(bus.reg_data_out), 32'(vecs[i].exp_reg));
    end
    bus.cpu_addr = 16'h0000;

    // Plain transfer from 0xC000.
    trigger(8'hC0);
    observe(8'hC0, -1, s);
    check_full("c0", s, 16'hC09F);
    tick();

    // Echo page: FE maps to DE.
    trigger(8'hFE);
    check("fe_reg", 32'(bus.reg_data_out), 32'hFE);
    observe(8'hDE, -1, s);
    check_full("fe", s, 16'hDE9F);
    tick();

    // Restart while reading idx 50.
    trigger(8'hC0);
    observe(8'hC0, 204, s);
    check("rs_pre_rd",   32'(bus.dma_read_enable), 32'd1);
    check("rs_pre_addr", 32'(bus.dma_addr),        32'hC032);
    check("rs_pre_n_wr", 32'(s.n_wr),              32'd50);
    check("rs_pre_err",  32'(s.rd_err + s.wr_err), 32'd0);
    trigger(8'hD0);
    observe(8'hD0, -1, s2);
    check_full("rs", s2, 16'hD09F);
    tick();

    // Trigger coinciding with the final phase edge of a transfer.
    trigger(8'hC1);
    observe(8'hC1, 643, s);
    check("fp_pre_active", 32'(bus.dma_active), 32'd1);
    check("fp_pre_n_wr",   32'(s.n_wr),          32'd160);
    trigger(8'hC2);
    observe(8'hC2, -1, s2);
    check_full("fp", s2, 16'hC29F);
    tick();

    // Reset asserted while reading idx 80.
    trigger(8'hC0);
    observe(8'hC0, 324, s);
    check("rr_pre_addr", 32'(bus.dma_addr), 32'hC050);
    #2 reset_n = 1'b0;
    #1;
    check("rr_rd",       32'(bus.dma_read_enable), 32'd0);
    check("rr_wr",       32'(bus.oam_write),       32'd0);
    check("rr_active",   32'(bus.dma_active),      32'd0);
    check("rr_reg",      32'(bus.reg_data_out),    32'hFF);
    check("rr_dma_addr", 32'(bus.dma_addr),        32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.dma_active || bus.dma_read_enable || bus.oam_write || bus.cpu_blocked) act++;
    end
    check("rr_idle_after", 32'(act), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
